// File: rtl/preemph_frame.sv
// preemph_frame
// Pre-emphasis, half-overlap framing and Hamming coefficient tagging in front
// of the two-cycle windowing multiplier. Every emitted sample leaves with a
// one-cycle en strobe, and strobes are always at least two cycles apart.
//
// Build option PREEMPH_EN: when defined, y = x - x_prev + (x_prev >>> PREEMPH_SHIFT).
// When it is undefined, the sample is passed through sign-extended and the
// x_prev register is not built.
//
// state  | meaning
// LIVE   | accepts din at most every other cycle and emits it with the current
//        | frame index; indices >= HOP are also written to the overlap RAM
// REPLAY | din_ready held low; overlap RAM slots 0..HOP-1 are re-emitted as
//        | indices 0..HOP-1 of the next frame, one strobe every two cycles
module preemph_frame #(
    parameter int FRAME_LEN     = 256,
    parameter int PREEMPH_SHIFT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [16:0] sample,
    output logic [4:0]  coef,
    output logic        en,
    output logic        frame_start,
    output logic        frame_done
);

    localparam int HOP = FRAME_LEN / 2;
    localparam int IW  = $clog2(FRAME_LEN);
    localparam int AW  = IW - 1;

    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] LAST_RP  = IW'(HOP - 1);

    // Parameter legality, caught at elaboration.
    if (FRAME_LEN < 8 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_len
        $error("preemph_frame: FRAME_LEN must be a power of two >= 8");
    end
    if (PREEMPH_SHIFT < 1 || PREEMPH_SHIFT > 15) begin : g_bad_shift
        $error("preemph_frame: PREEMPH_SHIFT must be in 1..15");
    end

    // Hamming half-table, built at elaboration in 2^-30 fixed point so that no
    // real arithmetic reaches synthesis. cos() is a Taylor series on an angle
    // folded into [0, pi/2].
    localparam longint ONE   = 64'sd1 << 30;
    localparam longint PI_FX = 64'sd3373259426;

    function automatic logic [HOP*5-1:0] build_rom();
        logic [HOP*5-1:0] rom;
        longint           x;
        longint           x2;
        longint           term;
        longint           c;
        longint           v;
        logic             neg;
        rom = '0;
        for (int n = 0; n < HOP; n++) begin
            x   = (2 * PI_FX * n) / (FRAME_LEN - 1);
            neg = 1'b0;
            if (x > PI_FX / 2) begin
                x   = PI_FX - x;
                neg = 1'b1;
            end
            x2   = (x * x) >>> 30;
            term = ONE;
            c    = ONE;
            for (int k = 1; k <= 12; k++) begin
                term = -((term * x2) >>> 30) / (2 * k * (2 * k - 1));
                c    = c + term;
            end
            if (neg) begin
                c = -c;
            end
            // round(16 * (0.54 - 0.46 * cos)), always positive, capped at 15
            v = (16 * (54 * ONE - 46 * c) + 50 * ONE) / (100 * ONE);
            if (v > 15) begin
                v = 15;
            end
            rom[n*5 +: 5] = 5'(v);
        end
        return rom;
    endfunction

    localparam logic [HOP*5-1:0] COEF_ROM = build_rom();

    typedef enum logic {
        LIVE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic          phase, phase_d;
    logic          ready_d;
    logic          en_d;
    logic          fs_d;
    logic          fd_d;
    logic [16:0]   sample_d;
    logic [4:0]    coef_d;
    logic          accept;
    logic [AW-1:0] slot;
    logic [AW-1:0] rom_addr;
    logic [4:0]    coef_lut;
    logic [16:0]   y;
    logic [16:0]   rd_data;
    logic          ram_we;
    logic [16:0]   ovl_ram [HOP];
`ifdef PREEMPH_EN
    logic [15:0]   x_prev, x_prev_d;
    logic [15:0]   x_tap;
`endif

    assign accept = din_valid & din_ready;

    // Live indices >= HOP map to overlap slot index-HOP, which is just the low
    // bits; replay reads slot idx directly while idx runs 0..HOP-1.
    assign slot = idx[AW-1:0];

    // min(n, FRAME_LEN-1-n): the upper half mirrors onto the table by inversion.
    assign rom_addr = idx[IW-1] ? ~idx[AW-1:0] : idx[AW-1:0];
    assign coef_lut = COEF_ROM[32'(rom_addr) * 5 +: 5];

    assign ram_we = (state == LIVE) & accept & idx[IW-1];

`ifdef PREEMPH_EN
    // The exact result always fits 17 bits, so 17-bit wrapping arithmetic is exact.
    assign x_tap = $signed(x_prev) >>> PREEMPH_SHIFT;
    assign y     = {din[15], din} - {x_prev[15], x_prev} + {x_tap[15], x_tap};
`else
    assign y = {din[15], din};
`endif

    // Next-state, index and emission decode.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        phase_d  = phase;
        ready_d  = 1'b0;
        en_d     = 1'b0;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        sample_d = sample;
        coef_d   = coef;
`ifdef PREEMPH_EN
        x_prev_d = x_prev;
`endif
        unique case (state)
            LIVE: begin
                if (accept) begin
                    en_d     = 1'b1;
                    sample_d = y;
                    coef_d   = coef_lut;
                    fs_d     = (idx == '0);
                    fd_d     = (idx == LAST_IDX);
`ifdef PREEMPH_EN
                    x_prev_d = din;
`endif
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        phase_d = 1'b0;
                        state_d = REPLAY;
                    end else begin
                        idx_d = idx + IDX_ONE;
                    end
                end else begin
                    // Ready again one cycle after any strobe, which keeps the
                    // strobe spacing at two cycles or more.
                    ready_d = 1'b1;
                end
            end
            REPLAY: begin
                // Phase 0 reads the slot into rd_data, phase 1 emits it.
                phase_d = ~phase;
                if (phase) begin
                    en_d     = 1'b1;
                    sample_d = rd_data;
                    coef_d   = coef_lut;
                    fs_d     = (idx == '0);
                    idx_d    = idx + IDX_ONE;
                    if (idx == LAST_RP) begin
                        state_d = LIVE;
                    end
                end
            end
            default: begin
                state_d = LIVE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LIVE;
            idx         <= '0;
            phase       <= 1'b0;
            din_ready   <= 1'b0;
            en          <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            sample      <= '0;
            coef        <= '0;
`ifdef PREEMPH_EN
            x_prev      <= '0;
`endif
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            phase       <= phase_d;
            din_ready   <= ready_d;
            en          <= en_d;
            frame_start <= fs_d;
            frame_done  <= fd_d;
            sample      <= sample_d;
            coef        <= coef_d;
`ifdef PREEMPH_EN
            x_prev      <= x_prev_d;
`endif
        end
    end

    // Overlap RAM: written by the live upper half, read one cycle ahead of each
    // replay emission. The two phases never run at the same time.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ovl_ram[slot] <= y;
        end
        rd_data <= ovl_ram[slot];
    end

endmodule

// File: doc/preemph_frame.md
# preemph_frame

Front-end stage that feeds the windowing multiplier. It accepts a continuous stream of 16-bit signed audio samples and applies first-order pre-emphasis. It slices the result into half-overlapping frames and presents each frame sample to the windowing stage with its 5-bit Hamming coefficient and a one-cycle `en` strobe. Emissions are spaced so that the two-cycle windowing stage never misses a strobe.

## Interface
- `FRAME_LEN`, 256: samples per frame; power of two, ≥ 8; hop is fixed at `FRAME_LEN/2`.
- `PREEMPH_SHIFT`, 5: pre-emphasis coefficient a = 1 − 2^−PREEMPH_SHIFT (31/32 by default).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `din` input 16: signed audio sample.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: block accepts `din` this cycle; a transfer occurs when `din_valid & din_ready`.
- `sample` output 17: signed pre-emphasized sample; drives the windowing stage's sample input.
- `coef` output 5: signed Hamming coefficient; drives the windowing stage's coefficient input.
- `en` output 1: one-cycle strobe; `sample`/`coef` are valid in that cycle.
- `frame_start` output 1: coincides with `en` of frame index 0.
- `frame_done` output 1: coincides with `en` of frame index `FRAME_LEN-1`.

## Operation
- Reset values: all outputs 0, including `din_ready`. Internal state is cleared: `x_prev`=0, index=0, history flag=0, state=LIVE.
- Pre-emphasis is computed on acceptance: y = din − x_prev + (x_prev >>> PREEMPH_SHIFT). The shift is arithmetic (floor), and y is a 17-bit signed result with no saturation needed. `x_prev` := din on every accepted sample. It carries across frame boundaries and is never reset except by `reset`.
- Coefficient: coef[n] = min(15, round(16·(0.54 − 0.46·cos(2πn/(FRAME_LEN−1))))). It is stored as a ROM of `FRAME_LEN/2` entries addressed by min(n, FRAME_LEN−1−n), and is always non-negative.
- Overlap buffer: `FRAME_LEN/2` × 17-bit RAM. Live samples with index ≥ HOP are written to slot index − HOP.
- States:
  - LIVE: accepts one sample per 2 cycles and emits it with the current index, then increments the index. After emitting index `FRAME_LEN-1`, the index wraps to 0, the history flag is set, and the state goes to REPLAY.
  - REPLAY: `din_ready`=0. Emits buffer slots 0..HOP−1 in order as frame indices 0..HOP−1, then goes to LIVE with index=HOP.
- The first frame after reset is fully live, because the history flag is 0.
- Buffer writes during LIVE (indices ≥ HOP) never overlap REPLAY reads, because the phases are strictly sequential.

## Timing
- Accept at edge t: `sample`, `coef` and `en` are registered and valid in cycle t+1, and `din_ready`=0 in cycle t+1. `din_ready` can be 1 again in cycle t+2.
- `en` is never high in two consecutive cycles. `sample` and `coef` hold their values until the next `en`.
- Live throughput is at most 1 sample per 2 cycles. When `din_valid` is low, nothing is emitted and state is held.
- REPLAY emits exactly one `en` every 2 cycles: HOP strobes in 2·HOP cycles. The first REPLAY `en` occurs 2 cycles after the `frame_done` strobe, and the 1-cycle RAM read latency is absorbed in the gap.
- Downstream latency (windowed output 2 cycles after `en`) is owned by the windowing stage. This block guarantees only the ≥2-cycle `en` spacing.
- Reset asserted mid-frame or mid-replay: all outputs go to 0 immediately and any partial frame is discarded. After release, the next frame is fully live with `x_prev`=0.

## Configuration
- `PREEMPH_EN` defined: pre-emphasis is applied as described above.
- `PREEMPH_EN` undefined: `sample` = sign-extended `din`, `x_prev` logic is removed, and `PREEMPH_SHIFT` is ignored. Framing, overlap and coefficients are unchanged.

## Test plan
- Reset: hold `reset`=0 with `din_valid`=1 → all outputs 0. First edge after release: `din_ready`=1.
- Constant `din`=1000, `PREEMPH_EN` on → `sample`[0]=1000, `sample`[1]=31, then 31 thereafter. `coef`[0]=1, `coef`[127]=15, `coef`[255]=1. `frame_start` is seen with index 0 and `frame_done` with index 255.
- Overlap: ramp `din`=n with `din_valid` held at 1 across 3 frames → frame 2 indices 0..127 equal frame 1 indices 128..255, and `din_ready`=0 for 256 cycles during replay. Frame 3 reuses frame 2's second half.
- Extremes: `din`=32767 then −32768 → `sample` = −64512, with no wrap.
- Random `din_valid` gaps → `en` never appears on adjacent cycles, every accepted sample is emitted exactly once and in order, and the frame count is correct.
- Reset at frame 2 index 100 → after release there is no replay, the first `sample` equals the sign-extended `din`, and `frame_start` occurs on the first live `en`.
